rob_commit: RTL
===============

Name: rob_commit

Overview:
In-order retirement stage directly downstream of the ROB. Each cycle it inspects up to NSIZE head entries and drives the ROB dequeue mask. It retires ready entries into the retirement RAT (RRAT) and returns superseded physical registers to the free list. On a committed mispredicted branch it raises a one-cycle flush and redirect, then drains and squashes all younger ROB entries, returning their physical registers before normal retirement resumes.

Parameters:
NSIZE, 1, retire width; must equal the ROB's NSIZE
DEPTH_BITS, 3, ROB index width
PR_BITS, 6, physical register index width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low (asserted when 0)
rob_head  in  rob_entry_t[NSIZE]  ROB dout; lane j is the j-th oldest entry
rob_elemcount  in  DEPTH_BITS+1  ROB occupancy
rob_dequeue  out  NSIZE  lanes popped this cycle; combinational
rrat_we  out  NSIZE  RRAT write enable per lane; registered
rrat_rd  out  5 x NSIZE  architectural rd per lane; registered
rrat_pd  out  PR_BITS x NSIZE  physical rd per lane; registered
free_we  out  NSIZE  free-list return enable per lane; registered
free_pd  out  PR_BITS x NSIZE  physical register returned; registered
flush  out  1  pipeline flush pulse; registered
redirect_pc  out  32  fetch target, valid while flush=1
busy  out  1  high in FLUSH or DRAIN; upstream must not enqueue into the ROB
instret  out  64  count of retired instructions

Behaviour:
- rob_entry_t must carry: ready, rd_arch[4:0], pd, pd_old, mispredict, target_pc[31:0].
- Reset (rst=0 at a clk edge): state=RUN; every registered output=0; instret=0. A reset in any state, including mid-DRAIN, returns to RUN with no flush emitted.
- lane_valid[j] = (j < rob_elemcount).
- RUN, retire rule:
  - lane j retires iff lane_valid[j] and rob_head[j].ready;
  - and every lane i<j retires;
  - and no lane i<j has mispredict=1.
  - The mispredicting lane itself retires.
- RUN outputs:
  - rob_dequeue[j] = retire[j], in the same cycle.
  - One cycle later, for each retired lane j with rd_arch!=0: rrat_we[j]=1, rrat_rd/rrat_pd=rd_arch/pd, free_we[j]=1, free_pd[j]=pd_old.
  - rd_arch==0: no RRAT write and no free-list return.
  - instret += popcount(retire), 64-bit, wraps.
- RUN->FLUSH when some retired lane has mispredict=1. That lane's target_pc is latched as redirect_pc.
- FLUSH (exactly 1 cycle): flush=1, redirect_pc valid, rob_dequeue=0. Writebacks registered from the previous RUN cycle still appear this cycle. Next state is DRAIN.
- DRAIN:
  - rob_dequeue[j] = lane_valid[j], regardless of ready.
  - Next cycle, for each squashed lane with rd_arch!=0: free_we=1, free_pd=pd (the new mapping). rrat_we=0.
  - instret unchanged.
  - Exit to RUN in the cycle after rob_elemcount==0 is observed with rob_dequeue=0. Entering DRAIN with an already empty ROB exits after one cycle.
- busy=1 in FLUSH and DRAIN. If an enqueue still lands during DRAIN, it is squashed like any other entry.
- Stall: head not ready (or ROB empty) in RUN -> rob_dequeue=0; registered enables deassert next cycle.
- Registered enables are single-cycle pulses; they are never held.

Decomposition:
- rv32i_types: rob_entry_t field set above; commit_state_t enum {RUN, FLUSH, DRAIN}.
- No sub-module is needed. The per-lane retire-prefix logic is a plain combinational loop inside rob_commit.

Test Plan:
- Reset: hold rst=0 for 2 cycles with ROB nonempty and ready -> rob_dequeue=0, flush=0, instret=0; first retire occurs the cycle after rst=1.
- NSIZE=2, head lanes ready {rd=5,pd=12,pd_old=3} and {rd=0}:
  - same cycle: rob_dequeue=2'b11;
  - next cycle: rrat_we=2'b01, rrat_rd[0]=5, rrat_pd[0]=12, free_pd[0]=3, free_we[1]=0;
  - instret=2.
- NSIZE=2, lane0 not ready, lane1 ready -> rob_dequeue=2'b00. When lane0 becomes ready -> 2'b11 in that cycle.
- Lane0 mispredict, target_pc=0x6000_0040, lane1 ready:
  - rob_dequeue=2'b01;
  - next cycle: flush=1, redirect_pc=0x6000_0040, busy=1.
- DRAIN with elemcount=3 (pd=20,21,22, NSIZE=2):
  - dequeues 2'b11 then 2'b01;
  - free_pd returns 20/21 then 22 with rrat_we=0;
  - RUN and busy=0 after elemcount reads 0.
- Drive rst=0 mid-DRAIN -> state RUN, all registered outputs 0, no further free_we pulses.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the retirement stage: ROB entry layout and commit FSM states.
package rv32i_types;

   localparam int ROB_PR_BITS = 6;

   typedef struct packed {
      logic                   ready;
      logic [4:0]             rd_arch;
      logic [ROB_PR_BITS-1:0] pd;
      logic [ROB_PR_BITS-1:0] pd_old;
      logic                   mispredict;
      logic [31:0]            target_pc;
   } rob_entry_t;

   typedef enum logic [1:0] {RUN, FLUSH, DRAIN} commit_state_t;

endpackage

// File: rtl/rob_commit.sv
// In-order retirement: pops ready ROB head entries, updates the RRAT and free list,
// and on a committed mispredict flushes, redirects, then squashes the younger entries.
module rob_commit
   import rv32i_types::*;
#(
   parameter int NSIZE      = 1,
   parameter int DEPTH_BITS = 3,
   parameter int PR_BITS    = ROB_PR_BITS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  rob_entry_t [NSIZE-1:0]           rob_head,
   input  logic [DEPTH_BITS:0]              rob_elemcount,
   output logic [NSIZE-1:0]                 rob_dequeue,
   output logic [NSIZE-1:0]                 rrat_we,
   output logic [NSIZE-1:0][4:0]            rrat_rd,
   output logic [NSIZE-1:0][PR_BITS-1:0]    rrat_pd,
   output logic [NSIZE-1:0]                 free_we,
   output logic [NSIZE-1:0][PR_BITS-1:0]    free_pd,
   output logic                             flush,
   output logic [31:0]                      redirect_pc,
   output logic                             busy,
   output logic [63:0]                      instret
);

   commit_state_t      state, state_nxt;
   logic [NSIZE-1:0]   lane_valid, retire, squash;
   logic               ok, mp_hit;
   logic [31:0]        mp_pc;
   logic [63:0]        ret_cnt;

   // Retire prefix: a lane goes only if all older lanes go and none of them mispredicted.
   always_comb begin
      lane_valid = '0;
      retire     = '0;
      squash     = '0;
      mp_hit     = 1'b0;
      mp_pc      = '0;
      ret_cnt    = '0;
      ok         = rst && (state == RUN);
      for (int j = 0; j < NSIZE; j++) begin
         lane_valid[j] = (j < int'(rob_elemcount));
         retire[j]     = ok && lane_valid[j] && rob_head[j].ready;
         ok            = retire[j] && !rob_head[j].mispredict;
         if (retire[j] && rob_head[j].mispredict) begin
            mp_hit = 1'b1;
            mp_pc  = rob_head[j].target_pc;
         end
         ret_cnt = ret_cnt + 64'(retire[j]);
      end
      if (rst && state == DRAIN) squash = lane_valid;
      rob_dequeue = retire | squash;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (mp_hit) state_nxt = FLUSH;
         FLUSH:   state_nxt = DRAIN;
         DRAIN:   if (rob_elemcount == '0) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   assign busy = (state != RUN);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= RUN;
         rrat_we     <= '0;
         rrat_rd     <= '0;
         rrat_pd     <= '0;
         free_we     <= '0;
         free_pd     <= '0;
         flush       <= 1'b0;
         redirect_pc <= '0;
         instret     <= '0;
      end else begin
         state   <= state_nxt;
         flush   <= mp_hit;
         instret <= instret + ret_cnt;
         if (mp_hit) redirect_pc <= mp_pc;
         for (int j = 0; j < NSIZE; j++) begin
            rrat_we[j] <= retire[j] && (rob_head[j].rd_arch != 5'd0);
            rrat_rd[j] <= rob_head[j].rd_arch;
            rrat_pd[j] <= rob_head[j].pd;
            free_we[j] <= (retire[j] || squash[j]) && (rob_head[j].rd_arch != 5'd0);
            // Retirement frees the superseded mapping; a squash frees the new one.
            free_pd[j] <= squash[j] ? rob_head[j].pd : rob_head[j].pd_old;
         end
      end
   end

endmodule
